// File: rtl/mem_req_arbiter.sv
// Two-master memory request arbiter: instruction fetch and data load/store share one
// downstream command port, one transaction in flight, round-robin on conflict.
module mem_req_arbiter #(
  parameter int WAIT_LIMIT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic [31:0] i_rdata,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  input  logic        bus_busy,
  input  logic        bus_valid,
  input  logic [31:0] bus_rdata,
  output logic        bus_read,
  output logic        bus_write,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic        timeout_err,
  output logic [1:0]  owner
);

  // state | meaning: IDLE arbitrate | ISSUE strobe bus when free | WAIT_RESP await bus_valid | RESPOND ack owner
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_RESP = 2'd2,
    RESPOND   = 2'd3
  } state_t;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_I    = 2'd1;
  localparam logic [1:0] OWN_D    = 2'd2;
  localparam logic [7:0] CNT_LAST = 8'(WAIT_LIMIT - 1);

  state_t      state_q, state_n;
  logic [1:0]  owner_q, owner_n;
  logic [31:0] addr_q, addr_n;
  logic [31:0] wdata_q, wdata_n;
  logic        write_q, write_n;
  logic [7:0]  cnt_q, cnt_n;
  logic [31:0] rdata_q, rdata_n;
  logic        last_d_q, last_d_n;
  logic        terr_q, terr_n;
  logic        d_pending;
  logic        grant_d;

  assign d_pending = d_read | d_write;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      owner_q  <= OWN_NONE;
      addr_q   <= '0;
      wdata_q  <= '0;
      write_q  <= 1'b0;
      cnt_q    <= '0;
      rdata_q  <= '0;
      last_d_q <= 1'b0;
      terr_q   <= 1'b0;
    end else begin
      state_q  <= state_n;
      owner_q  <= owner_n;
      addr_q   <= addr_n;
      wdata_q  <= wdata_n;
      write_q  <= write_n;
      cnt_q    <= cnt_n;
      rdata_q  <= rdata_n;
      last_d_q <= last_d_n;
      terr_q   <= terr_n;
    end
  end

  always_comb begin
    state_n   = state_q;
    owner_n   = owner_q;
    addr_n    = addr_q;
    wdata_n   = wdata_q;
    write_n   = write_q;
    cnt_n     = cnt_q;
    rdata_n   = rdata_q;
    last_d_n  = last_d_q;
    terr_n    = terr_q;
    grant_d   = 1'b0;
    bus_read  = 1'b0;
    bus_write = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_req || d_pending) begin
          // data wins when it is alone or when instruction was served last
          grant_d = d_pending && (!i_req || !last_d_q);
          owner_n = grant_d ? OWN_D : OWN_I;
          addr_n  = grant_d ? d_addr : i_addr;
          write_n = grant_d && d_write;
          wdata_n = (grant_d && d_write) ? d_wdata : 32'd0;
          state_n = ISSUE;
        end
      end
      ISSUE: begin
        if (!bus_busy) begin
          bus_read  = !write_q;
          bus_write = write_q;
          cnt_n     = '0;
          state_n   = WAIT_RESP;
        end
      end
      WAIT_RESP: begin
        // a completion on the final counted cycle still wins over the timeout
        if (bus_valid) begin
          rdata_n = write_q ? 32'd0 : bus_rdata;
          state_n = RESPOND;
        end else if (cnt_q == CNT_LAST) begin
          terr_n  = 1'b1;
          rdata_n = 32'd0;
          state_n = RESPOND;
        end else begin
          cnt_n = cnt_q + 8'd1;
        end
      end
      RESPOND: begin
        last_d_n = (owner_q == OWN_D);
        owner_n  = OWN_NONE;
        addr_n   = '0;
        wdata_n  = '0;
        write_n  = 1'b0;
        cnt_n    = '0;
        rdata_n  = '0;
        state_n  = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign i_ack       = (state_q == RESPOND) && (owner_q == OWN_I);
  assign d_ack       = (state_q == RESPOND) && (owner_q == OWN_D);
  assign i_rdata     = i_ack ? rdata_q : 32'd0;
  assign d_rdata     = d_ack ? rdata_q : 32'd0;
  assign bus_addr    = addr_q;
  assign bus_wdata   = wdata_q;
  assign timeout_err = terr_q;
  assign owner       = owner_q;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Self-checking bench for mem_req_arbiter: directed scenarios plus a randomized run
// against a transaction-level model with a memory-backed bus responder.
module tb_mem_req_arbiter;

  localparam int WL = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        d_read, d_write;
  logic [31:0] d_addr, d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        bus_busy, bus_valid;
  logic [31:0] bus_rdata;
  logic        bus_read, bus_write;
  logic [31:0] bus_addr, bus_wdata;
  logic        timeout_err;
  logic [1:0]  owner;

  always #5 clk = ~clk;

  mem_req_arbiter #(.WAIT_LIMIT(WL)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .bus_busy(bus_busy), .bus_valid(bus_valid), .bus_rdata(bus_rdata),
    .bus_read(bus_read), .bus_write(bus_write), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .timeout_err(timeout_err), .owner(owner)
  );

  int checks = 0;
  int failures = 0;

  // bus-side memory and responder
  logic [31:0] mem [logic [31:0]];
  bit          rsp_pending;
  int          rsp_count;
  logic [31:0] rsp_data;
  int          next_lat;
  int          busy_left;
  int          busy_pct;
  int          spur_pct;

  // per-cycle observations
  logic        o_rd, o_wr, o_iack, o_dack, o_terr;
  logic [31:0] o_addr, o_wdata, o_irdata, o_drdata;
  logic [1:0]  o_owner;

  // per-transaction summary from run_until_ack
  int          n_rd, n_wr, s_cyc, ack_cyc, ack_who, stray, terr_first;
  logic [31:0] s_addr, s_wdata, ack_data;
  logic [1:0]  s_owner;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'hA5C3_0001;
  endfunction

  // One clock cycle: drive bus side, sample outputs mid-cycle, then advance past the edge.
  task automatic cycle();
    bus_busy = (busy_left > 0) || ($urandom_range(99) < busy_pct);
    if (busy_left > 0) busy_left--;
    bus_valid = 1'b0;
    bus_rdata = $urandom;
    if (rsp_pending) begin
      if (rsp_count == 0) begin
        bus_valid   = 1'b1;
        bus_rdata   = rsp_data;
        rsp_pending = 1'b0;
      end else begin
        rsp_count--;
      end
    end else if ($urandom_range(99) < spur_pct) begin
      bus_valid = 1'b1;
    end
    #1;
    o_rd = bus_read;   o_wr = bus_write;  o_addr = bus_addr;  o_wdata = bus_wdata;
    o_iack = i_ack;    o_irdata = i_rdata; o_dack = d_ack;     o_drdata = d_rdata;
    o_terr = timeout_err; o_owner = owner;
    if (o_rd || o_wr) begin
      if (o_wr) mem[o_addr] = o_wdata;
      rsp_data    = mem_rd(o_addr);
      rsp_pending = 1'b1;
      rsp_count   = next_lat - 1;
    end
    if (o_iack || o_dack) rsp_pending = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic run_until_ack(input int max_cyc, input bit drop);
    n_rd = 0; n_wr = 0; s_cyc = -1; ack_cyc = -1; ack_who = 0; stray = 0; terr_first = -1;
    s_addr = '0; s_wdata = '0; ack_data = '0; s_owner = '0;
    for (int c = 1; c <= max_cyc; c++) begin
      cycle();
      if (o_rd || o_wr) begin
        n_rd += int'(o_rd);
        n_wr += int'(o_wr);
        if (s_cyc < 0) begin
          s_cyc = c; s_addr = o_addr; s_wdata = o_wdata; s_owner = o_owner;
        end
      end
      if ((!o_iack && o_irdata != 0) || (!o_dack && o_drdata != 0)) stray++;
      if (o_terr && terr_first < 0) terr_first = c;
      if (o_iack || o_dack) begin
        ack_cyc  = c;
        ack_who  = (o_iack && o_dack) ? 3 : (o_iack ? 1 : 2);
        ack_data = o_iack ? o_irdata : o_drdata;
        if (drop) begin
          if (o_iack) i_req = 1'b0;
          if (o_dack) begin d_read = 1'b0; d_write = 1'b0; end
        end
        break;
      end
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    i_req = 1'b0; d_read = 1'b0; d_write = 1'b0;
    rsp_pending = 1'b0; busy_left = 0; busy_pct = 0; spur_pct = 0; next_lat = 1;
    bus_busy = 1'b0; bus_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    i_req = 1'b1; i_addr = 32'h1234; d_read = 1'b1; d_write = 1'b1; d_addr = 32'h88; d_wdata = 32'h77;
    bus_busy = 1'b0; bus_valid = 1'b1; bus_rdata = 32'hFFFF_FFFF;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({owner, bus_read, bus_write, i_ack, d_ack, timeout_err} !== 7'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got owner=%0d rd=%b wr=%b iack=%b dack=%b terr=%b, all 0 required",
               owner, bus_read, bus_write, i_ack, d_ack, timeout_err);
    end
    checks++;
    if ({bus_addr, bus_wdata, i_rdata, d_rdata} !== 128'b0) begin
      failures++;
      $display("FAIL reset_data: got addr=%h wdata=%h irdata=%h drdata=%h, all 0 required",
               bus_addr, bus_wdata, i_rdata, d_rdata);
    end
    apply_reset();
  endtask

  task automatic test_single_fetch();
    apply_reset();
    mem[32'h100] = 32'hDEAD_BEEF;
    i_req = 1'b1; i_addr = 32'h100;
    run_until_ack(12, 1'b1);
    checks++;
    if (n_rd !== 1 || n_wr !== 0) begin
      failures++; $display("FAIL fetch_strobes: got rd=%0d wr=%0d, required rd=1 wr=0", n_rd, n_wr);
    end
    checks++;
    if (s_addr !== 32'h100 || s_cyc !== 2 || s_owner !== 2'd1) begin
      failures++;
      $display("FAIL fetch_cmd: got addr=%h cyc=%0d owner=%0d, required 100/2/1", s_addr, s_cyc, s_owner);
    end
    checks++;
    if (ack_cyc !== 4 || ack_who !== 1 || ack_data !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL fetch_ack: got cyc=%0d who=%0d data=%h, required 4/1/deadbeef", ack_cyc, ack_who, ack_data);
    end
    cycle();
    checks++;
    if (o_owner !== 2'd0 || o_iack !== 1'b0 || o_rd !== 1'b0 || o_irdata !== 32'd0 || stray !== 0) begin
      failures++;
      $display("FAIL fetch_after: got owner=%0d iack=%b rd=%b irdata=%h stray=%0d, required idle",
               o_owner, o_iack, o_rd, o_irdata, stray);
    end
  endtask

  task automatic test_arbitration();
    int exp_who;
    logic [31:0] exp_addr;
    apply_reset();
    i_req = 1'b1; i_addr = 32'h200;
    d_read = 1'b1; d_addr = 32'h204;
    for (int k = 0; k < 4; k++) begin
      exp_who  = (k % 2 == 0) ? 2 : 1;
      exp_addr = (exp_who == 2) ? 32'h204 : 32'h200;
      run_until_ack(20, 1'b0);
      checks++;
      if (ack_who !== exp_who || s_addr !== exp_addr || ack_cyc !== 4 || ack_data !== mem_rd(exp_addr)) begin
        failures++;
        $display("FAIL arb_grant%0d: got who=%0d addr=%h cyc=%0d data=%h, required who=%0d addr=%h cyc=4 data=%h",
                 k, ack_who, s_addr, ack_cyc, ack_data, exp_who, exp_addr, mem_rd(exp_addr));
      end
    end
    i_req = 1'b0; d_read = 1'b0;
    cycle();
  endtask

  task automatic test_busy_stall();
    apply_reset();
    d_write = 1'b1; d_addr = 32'h20; d_wdata = 32'h55;
    busy_left = 4;
    run_until_ack(20, 1'b1);
    checks++;
    if (n_wr !== 1 || n_rd !== 0 || s_cyc !== 5) begin
      failures++; $display("FAIL busy_strobe: got wr=%0d rd=%0d cyc=%0d, required 1/0/5", n_wr, n_rd, s_cyc);
    end
    checks++;
    if (s_addr !== 32'h20 || s_wdata !== 32'h55) begin
      failures++; $display("FAIL busy_cmd: got addr=%h wdata=%h, required 20/55", s_addr, s_wdata);
    end
    checks++;
    if (ack_who !== 2 || ack_cyc !== 7 || ack_data !== 32'd0) begin
      failures++; $display("FAIL busy_ack: got who=%0d cyc=%0d data=%h, required 2/7/0", ack_who, ack_cyc, ack_data);
    end
  endtask

  task automatic test_timeout();
    apply_reset();
    mem[32'h40] = 32'h1234_5678;
    d_read = 1'b1; d_addr = 32'h40;
    next_lat = 1000;
    run_until_ack(40, 1'b1);
    checks++;
    if (ack_who !== 2 || ack_cyc !== WL + 3 || ack_data !== 32'd0) begin
      failures++;
      $display("FAIL timeout_ack: got who=%0d cyc=%0d data=%h, required 2/%0d/0", ack_who, ack_cyc, ack_data, WL + 3);
    end
    checks++;
    if (terr_first !== WL + 3) begin
      failures++; $display("FAIL timeout_flag: got first cycle %0d, required %0d", terr_first, WL + 3);
    end
    next_lat = 1;
    i_req = 1'b1; i_addr = 32'h100;
    run_until_ack(12, 1'b1);
    cycle();
    checks++;
    if (o_terr !== 1'b1 || ack_cyc !== 4) begin
      failures++; $display("FAIL timeout_sticky: got terr=%b ack_cyc=%0d, required 1/4", o_terr, ack_cyc);
    end
    apply_reset();
    cycle();
    checks++;
    if (o_terr !== 1'b0) begin
      failures++; $display("FAIL timeout_clear: got terr=%b after reset, required 0", o_terr);
    end
  endtask

  task automatic test_valid_at_limit();
    apply_reset();
    mem[32'h44] = 32'hCAFE_0044;
    d_read = 1'b1; d_addr = 32'h44;
    next_lat = WL;
    run_until_ack(40, 1'b1);
    checks++;
    if (ack_cyc !== WL + 3 || ack_data !== 32'hCAFE_0044 || terr_first !== -1) begin
      failures++;
      $display("FAIL limit_success: got cyc=%0d data=%h terr_at=%0d, required %0d/cafe0044/none",
               ack_cyc, ack_data, terr_first, WL + 3);
    end
    d_read = 1'b1; d_addr = 32'h44;
    next_lat = WL + 1;
    run_until_ack(40, 1'b1);
    checks++;
    if (ack_cyc !== WL + 3 || ack_data !== 32'd0 || terr_first !== WL + 3) begin
      failures++;
      $display("FAIL limit_plus1: got cyc=%0d data=%h terr_at=%0d, required %0d/0/%0d",
               ack_cyc, ack_data, terr_first, WL + 3, WL + 3);
    end
  endtask

  task automatic test_reset_mid();
    int acks;
    apply_reset();
    i_req = 1'b1; i_addr = 32'h300;
    next_lat = 1000;
    acks = 0;
    for (int c = 0; c < 5; c++) begin
      cycle();
      if (o_iack) acks++;
    end
    rst = 1'b1;
    #1;
    checks++;
    if (owner !== 2'd0 || bus_addr !== 32'd0 || i_ack !== 1'b0 || bus_read !== 1'b0 || acks !== 0) begin
      failures++;
      $display("FAIL midrst_outputs: got owner=%0d addr=%h iack=%b rd=%b acks=%0d, required all 0",
               owner, bus_addr, i_ack, bus_read, acks);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    rsp_pending = 1'b0;
    next_lat = 1;
    run_until_ack(12, 1'b1);
    checks++;
    if (n_rd !== 1 || s_addr !== 32'h300 || ack_cyc !== 4 || ack_who !== 1 || ack_data !== mem_rd(32'h300)) begin
      failures++;
      $display("FAIL midrst_reissue: got rd=%0d addr=%h cyc=%0d who=%0d data=%h, required 1/300/4/1/%h",
               n_rd, s_addr, ack_cyc, ack_who, ack_data, mem_rd(32'h300));
    end
  endtask

  task automatic test_read_write_both();
    apply_reset();
    d_read = 1'b1; d_write = 1'b1; d_addr = 32'h60; d_wdata = 32'hA5A5_1234;
    run_until_ack(12, 1'b1);
    checks++;
    if (n_rd !== 0 || n_wr !== 1 || s_wdata !== 32'hA5A5_1234 || ack_data !== 32'd0 || ack_who !== 2) begin
      failures++;
      $display("FAIL rw_both: got rd=%0d wr=%0d wdata=%h data=%h who=%0d, required 0/1/a5a51234/0/2",
               n_rd, n_wr, s_wdata, ack_data, ack_who);
    end
  endtask

  task automatic test_drop_mid();
    apply_reset();
    i_req = 1'b1; i_addr = 32'h104;
    cycle();
    cycle();
    i_req = 1'b0;
    run_until_ack(12, 1'b1);
    checks++;
    if (ack_who !== 1 || ack_cyc !== 2 || ack_data !== mem_rd(32'h104)) begin
      failures++;
      $display("FAIL drop_mid: got who=%0d cyc=%0d data=%h, required 1/2/%h", ack_who, ack_cyc, ack_data, mem_rd(32'h104));
    end
  endtask

  task automatic test_random();
    bit          m_busy, m_write, m_last_d, m_any_to;
    int          m_who, m_wait, m_strobes, m_strobe_cyc, m_lat, n_done, op, bad;
    logic [31:0] m_addr, m_wdata, m_exp;
    apply_reset();
    busy_pct = 25; spur_pct = 15;
    m_busy = 0; m_last_d = 0; m_any_to = 0; n_done = 0; bad = 0;
    m_who = 0; m_wait = 0; m_strobes = 0; m_strobe_cyc = 0; m_lat = 0; m_write = 0;
    m_addr = '0; m_wdata = '0; m_exp = '0;
    for (int cyc = 0; cyc < 4000 && n_done < 120; cyc++) begin
      if (!i_req) begin
        if ($urandom_range(99) < 40) begin
          i_req = 1'b1; i_addr = {26'd0, 4'($urandom_range(15)), 2'b00};
        end else begin
          i_addr = $urandom;
        end
      end
      if (!(d_read || d_write)) begin
        if ($urandom_range(99) < 40) begin
          op = $urandom_range(2);
          d_read = (op != 1); d_write = (op != 0);
          d_addr = {26'd0, 4'($urandom_range(15)), 2'b00}; d_wdata = $urandom;
        end else begin
          d_addr = $urandom; d_wdata = $urandom;
        end
      end
      next_lat = $urandom_range(WL + 2, 1);
      if (!m_busy && (i_req || d_read || d_write)) begin
        m_busy    = 1'b1;
        m_who     = ((d_read || d_write) && (!i_req || !m_last_d)) ? 2 : 1;
        m_addr    = (m_who == 2) ? d_addr : i_addr;
        m_write   = (m_who == 2) && d_write;
        m_wdata   = d_wdata;
        m_strobes = 0; m_wait = 0;
      end
      cycle();
      if (m_busy) m_wait++;
      if (o_rd || o_wr) begin
        checks++;
        if (!m_busy || o_wr !== m_write || o_rd !== !m_write || o_addr !== m_addr ||
            (m_write && o_wdata !== m_wdata) || o_owner !== 2'(m_who)) begin
          failures++;
          $display("FAIL rand_cmd: got rd=%b wr=%b addr=%h wdata=%h owner=%0d, required wr=%b addr=%h wdata=%h owner=%0d",
                   o_rd, o_wr, o_addr, o_wdata, o_owner, m_write, m_addr, m_wdata, m_who);
        end
        m_strobes++;
        m_strobe_cyc = m_wait;
        m_lat        = next_lat;
        m_exp        = (!m_write && next_lat <= WL) ? mem_rd(m_addr) : 32'd0;
        if (next_lat > WL) m_any_to = 1'b1;
      end
      if ((!o_iack && o_irdata !== 32'd0) || (!o_dack && o_drdata !== 32'd0)) begin
        bad++;
        checks++; failures++;
        $display("FAIL rand_stray_rdata: got irdata=%h drdata=%h without ack, required 0", o_irdata, o_drdata);
      end
      if (o_iack || o_dack) begin
        checks++;
        if (!m_busy || (o_iack && o_dack) || (o_iack ? 1 : 2) != m_who) begin
          failures++;
          $display("FAIL rand_ack_who: got iack=%b dack=%b, required owner %0d (busy=%b)", o_iack, o_dack, m_who, m_busy);
        end
        checks++;
        if ((o_iack ? o_irdata : o_drdata) !== m_exp || m_strobes != 1) begin
          failures++;
          $display("FAIL rand_ack_data: got data=%h strobes=%0d, required data=%h strobes=1",
                   o_iack ? o_irdata : o_drdata, m_strobes, m_exp);
        end
        checks++;
        if (m_wait != m_strobe_cyc + ((m_lat < WL) ? m_lat : WL) + 1) begin
          failures++;
          $display("FAIL rand_ack_time: got cycle %0d, required %0d", m_wait,
                   m_strobe_cyc + ((m_lat < WL) ? m_lat : WL) + 1);
        end
        m_last_d = (m_who == 2);
        m_busy   = 1'b0;
        if (m_who == 1) i_req = 1'b0;
        else begin d_read = 1'b0; d_write = 1'b0; end
        n_done++;
      end
      if ((m_busy && m_wait > WL + 60) || bad > 5) begin
        checks++; failures++;
        $display("FAIL rand_hang: transaction open for %0d cycles, required ack within %0d", m_wait, WL + 60);
        break;
      end
    end
    checks++;
    if (n_done < 120) begin
      failures++; $display("FAIL rand_progress: got %0d completions, required 120", n_done);
    end
    checks++;
    if (o_terr !== m_any_to) begin
      failures++; $display("FAIL rand_terr: got timeout_err=%b, required %b", o_terr, m_any_to);
    end
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_arbitration();
    test_busy_stall();
    test_timeout();
    test_valid_at_limit();
    test_reset_mid();
    test_read_write_both();
    test_drop_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
